// File: rtl/register_consolidation_unit_if.sv
// Consolidation handshake bundle: power-manager start/done, AMT lookup, and one RF read and one RF write port.
// master = surrounding core (power manager, AMT, RF); slave = register_consolidation_unit.
interface register_consolidation_unit_if #(
  parameter int NUM_ARCH_REGS = 34,
  parameter int NUM_PHYS_REGS = 128,
  parameter int DATA_WIDTH    = 64
);
  localparam int AW = $clog2(NUM_ARCH_REGS);
  localparam int PW = $clog2(NUM_PHYS_REGS);

  logic                  begin_consolidation;
  logic [AW-1:0]         amt_addr;
  logic [PW-1:0]         amt_phy_reg;
  logic                  rf_rd_en;
  logic [PW-1:0]         rf_rd_addr;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  rf_wr_en;
  logic [PW-1:0]         rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  busy;
  logic                  consolidation_done;

  modport master (
    output begin_consolidation, amt_phy_reg, rf_rd_data,
    input  amt_addr, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, busy, consolidation_done
  );

  modport slave (
    input  begin_consolidation, amt_phy_reg, rf_rd_data,
    output amt_addr, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, busy, consolidation_done
  );
endinterface

// File: rtl/register_consolidation_unit.sv
// Moves every architectural value from its AMT-mapped physical register into physical register [arch index].
// Optional REG_CONSOLIDATE_SKIP_IDENTITY_EN suppresses the write for entries already in place.
module register_consolidation_unit #(
  parameter int NUM_ARCH_REGS = 34,
  parameter int NUM_PHYS_REGS = 128,
  parameter int DATA_WIDTH    = 64
) (
  input logic clk,
  input logic rst,
  register_consolidation_unit_if.slave bus
);
  localparam int AW = $clog2(NUM_ARCH_REGS);
  localparam int PW = $clog2(NUM_PHYS_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_ARCH_REGS - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         idx, idx_nxt;
  logic [DATA_WIDTH-1:0] stage_buf [NUM_ARCH_REGS];
  logic                  wr_allow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Every source is staged before the first write, so overlapping source/destination sets stay intact.
  always_ff @(posedge clk) begin
    if (state == READ && idx != '0)
      stage_buf[idx - AW'(1)] <= bus.rf_rd_data;
    else if (state == DRAIN)
      stage_buf[LAST] <= bus.rf_rd_data;
  end

`ifdef REG_CONSOLIDATE_SKIP_IDENTITY_EN
  logic [NUM_ARCH_REGS-1:0] identity;

  always_ff @(posedge clk) begin
    if (state == READ)
      identity[idx] <= (bus.amt_phy_reg == PW'(idx));
  end

  assign wr_allow = ~identity[idx];
`else
  assign wr_allow = 1'b1;
`endif

  // AMT lookup feeds the RF read address combinationally during READ.
  assign bus.amt_addr   = (state == READ) ? idx : '0;
  assign bus.rf_rd_addr = (state == READ) ? bus.amt_phy_reg : '0;

  always_comb begin
    state_nxt              = state;
    idx_nxt                = idx;
    bus.busy               = 1'b0;
    bus.rf_rd_en           = 1'b0;
    bus.rf_wr_en           = 1'b0;
    bus.rf_wr_addr         = '0;
    bus.rf_wr_data         = '0;
    bus.consolidation_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.begin_consolidation) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end
      end
      READ: begin
        bus.busy     = 1'b1;
        bus.rf_rd_en = 1'b1;
        if (idx == LAST) state_nxt = DRAIN;
        else             idx_nxt   = idx + AW'(1);
      end
      DRAIN: begin
        bus.busy  = 1'b1;
        state_nxt = WRITE;
        idx_nxt   = '0;
      end
      WRITE: begin
        bus.busy       = 1'b1;
        bus.rf_wr_en   = wr_allow;
        bus.rf_wr_addr = PW'(idx);
        bus.rf_wr_data = stage_buf[idx];
        if (idx == LAST) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + AW'(1);
        end
      end
      DONE: begin
        bus.busy               = 1'b1;
        bus.consolidation_done = 1'b1;
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_register_consolidation_unit.sv
// Scoreboarded bench for register_consolidation_unit: behavioural AMT/RF around the DUT,
// expected writes and done cycles queued at stimulus time, popped by a negedge monitor.
module tb_register_consolidation_unit;
  localparam int N  = 34;
  localparam int NP = 128;
  localparam int DW = 64;
  localparam int PW = 7;
`ifdef REG_CONSOLIDATE_SKIP_IDENTITY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_consolidation_unit_if #(.NUM_ARCH_REGS(N), .NUM_PHYS_REGS(NP), .DATA_WIDTH(DW)) bus ();

  register_consolidation_unit #(.NUM_ARCH_REGS(N), .NUM_PHYS_REGS(NP), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [PW-1:0]    amt [64];
  logic [DW-1:0]    rf  [NP];
  logic [DW-1:0]    rd_q = '0;
  logic             load_pat = 1'b0;
  int               pat = 1;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [PW+DW-1:0] wr_q [$];
  int               done_q [$];
  int               t0, t1, bad;

  function automatic logic [63:0] init_val(input int pt, input int p);
    case (pt)
      2: begin
        if (p == 0) return 64'hA;
        if (p == 5) return 64'hB;
        return 64'h2000 + 64'(p);
      end
      3:       return 64'h3000 + 64'(p);
      default: return 64'h1000 + 64'(p);
    endcase
  endfunction

  assign bus.amt_phy_reg = amt[bus.amt_addr];
  assign bus.rf_rd_data  = rd_q;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load_pat) begin
      for (int p = 0; p < NP; p++) rf[p] <= init_val(pat, p);
    end else if (bus.rf_wr_en) begin
      rf[bus.rf_wr_addr] <= bus.rf_wr_data;
    end
    if (bus.rf_rd_en) rd_q <= rf[bus.rf_rd_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [PW+DW-1:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (bus.rf_wr_en === 1'b1) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got addr %0d data %0h at cycle %0d, required no write",
                   bus.rf_wr_addr, bus.rf_wr_data, cyc);
        end else begin
          e = wr_q.pop_front();
          if ({bus.rf_wr_addr, bus.rf_wr_data} !== e) begin
            n_fail++;
            $display("FAIL write_data: got addr %0d data %0h, required addr %0d data %0h",
                     bus.rf_wr_addr, bus.rf_wr_data, e[PW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (bus.consolidation_done === 1'b1) begin
        n_checks++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
        end else begin
          d = done_q.pop_front();
          if (cyc != d) begin
            n_fail++;
            $display("FAIL done_cycle: got cycle %0d, required %0d", cyc, d);
          end
        end
      end
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic load(input int pt);
    pat      = pt;
    load_pat = 1'b1;
    tick(1);
    load_pat = 1'b0;
  endtask

  task automatic start_run(output int ts);
    for (int a = 0; a < N; a++)
      if (!SKIP || amt[a] != PW'(a))
        wr_q.push_back({PW'(a), init_val(pat, int'(amt[a]))});
    ts = cyc;
    done_q.push_back(cyc + 2 * N + 2);
    bus.begin_consolidation = 1'b1;
  endtask

  task automatic finish_run(input string name, input int ts);
    tick(ts + 75 - cyc);
    check({name, "_done_pending"}, 64'(done_q.size()), 64'd0);
    check({name, "_writes_pending"}, 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    bus.begin_consolidation = 1'b0;
    for (int i = 0; i < 64; i++) amt[i] = '0;
    fork
      monitor();
    join_none

    load(1);
    tick(2);
    check("reset_ctrl", 64'({bus.busy, bus.rf_rd_en, bus.rf_wr_en, bus.consolidation_done}), 64'd0);
    check("reset_addr", 64'({bus.amt_addr, bus.rf_rd_addr, bus.rf_wr_addr}), 64'd0);
    check("reset_wdata", bus.rf_wr_data, 64'd0);
    rst = 1'b0;
    tick(1);

    for (int i = 0; i < 100; i++) begin
      check("idle_quiet", 64'({bus.busy, bus.rf_rd_en, bus.rf_wr_en, bus.consolidation_done}), 64'd0);
      tick(1);
    end

    // Shuffled mapping: AMT[a] = 127-a
    for (int a = 0; a < N; a++) amt[a] = PW'(127 - a);
    load(1);
    start_run(t0);
    check("begin_cycle_idle", 64'(bus.busy), 64'd0);
    tick(1);
    bus.begin_consolidation = 1'b0;
    check("read_first_ctrl", 64'({bus.busy, bus.rf_rd_en}), 64'd3);
    check("read_first_addr", 64'({bus.amt_addr, bus.rf_rd_addr}), 64'd127);
    tick(N);
    check("drain_ctrl", 64'({bus.busy, bus.rf_rd_en, bus.rf_wr_en}), 64'b100);
    finish_run("shuffle", t0);
    check("shuffle_rf0", rf[0], 64'h107F);
    check("shuffle_rf33", rf[33], 64'h105E);
    bad = 0;
    for (int p = N; p < NP; p++) if (rf[p] !== 64'h1000 + 64'(p)) bad++;
    check("shuffle_untouched", 64'(bad), 64'd0);

    // Overlapping swap of entries 0 and 5
    for (int a = 0; a < N; a++) amt[a] = PW'(a);
    amt[0] = 7'd5;
    amt[5] = 7'd0;
    load(2);
    start_run(t0);
    tick(1);
    bus.begin_consolidation = 1'b0;
    finish_run("overlap", t0);
    check("overlap_rf0", rf[0], 64'hB);
    check("overlap_rf5", rf[5], 64'hA);
    check("overlap_rf1", rf[1], 64'h2001);

    // Identity mapping
    for (int a = 0; a < N; a++) amt[a] = PW'(a);
    load(3);
    start_run(t0);
    tick(1);
    bus.begin_consolidation = 1'b0;
    finish_run("identity", t0);
    check("identity_rf7", rf[7], 64'h3007);

    // Begin pulses while busy are ignored; first IDLE cycle after DONE accepts
    for (int a = 0; a < N; a++) amt[a] = PW'(127 - a);
    load(1);
    start_run(t0);
    tick(1);
    bus.begin_consolidation = 1'b0;
    tick(9);
    bus.begin_consolidation = 1'b1;
    tick(1);
    bus.begin_consolidation = 1'b0;
    check("restart_ignored_idx", 64'(bus.amt_addr), 64'd10);
    tick(58);
    check("pre_done_busy", 64'({bus.busy, bus.consolidation_done}), 64'b10);
    tick(1);
    check("done_cycle_ctrl", 64'({bus.busy, bus.consolidation_done}), 64'b11);
    bus.begin_consolidation = 1'b1;
    tick(1);
    check("after_done_idle", 64'({bus.busy, bus.consolidation_done}), 64'd0);
    start_run(t1);
    tick(1);
    bus.begin_consolidation = 1'b0;
    finish_run("back_to_back", t1);

    // Reset in the middle of WRITE
    load(1);
    start_run(t0);
    tick(1);
    bus.begin_consolidation = 1'b0;
    tick(39);
    check("writes_before_reset", 64'(wr_q.size()), 64'd30);
    rst = 1'b1;
    #1;
    check("midreset_ctrl", 64'({bus.busy, bus.rf_rd_en, bus.rf_wr_en, bus.consolidation_done}), 64'd0);
    check("midreset_addr", 64'({bus.amt_addr, bus.rf_rd_addr, bus.rf_wr_addr}), 64'd0);
    check("midreset_wdata", bus.rf_wr_data, 64'd0);
    wr_q.delete();
    done_q.delete();
    tick(2);
    rst = 1'b0;
    check("midreset_rf0", rf[0], 64'h107F);
    check("midreset_rf4", rf[4], 64'h1004);
    tick(t0 + 80 - cyc);
    check("post_reset_quiet", 64'({bus.busy, bus.rf_wr_en, bus.consolidation_done}), 64'd0);
    start_run(t1);
    tick(1);
    bus.begin_consolidation = 1'b0;
    finish_run("after_reset", t1);
    check("after_reset_rf4", rf[4], 64'h107B);
    check("after_reset_rf33", rf[33], 64'h105E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
